// File: rtl/tpu_pkg.sv
// Shared types and geometry for the TPU tile scheduler.
package tpu_pkg;

    localparam int SIZE       = 8;
    localparam int TILE_WORDS = SIZE * SIZE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_STORE,
        S_FIN
    } state_t;

endpackage

// File: rtl/tpu_tile_scheduler_if.sv
// Scheduler-side bus towards the DMA, the 8x8 core and the unified buffer.
interface tpu_tile_scheduler_if #(
    parameter int ADDR_W = 16
);

    logic              load_req;
    logic              load_ack;
    logic [ADDR_W-1:0] wt_addr;
    logic [ADDR_W-1:0] act_addr;
    logic              core_start;
    logic              core_done;
    logic              acc_first;
    logic              acc_last;
    logic              store_req;
    logic              store_ack;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output load_req, wt_addr, act_addr, core_start, acc_first, acc_last, store_req, out_addr,
        input  load_ack, core_done, store_ack
    );

    modport slave (
        input  load_req, wt_addr, act_addr, core_start, acc_first, acc_last, store_req, out_addr,
        output load_ack, core_done, store_ack
    );

endinterface

// File: rtl/tile_index_counter.sv
// Nested m/n/k tile indices with registered tile base addresses and k-position flags.
module tile_index_counter
    import tpu_pkg::*;
#(
    parameter int TILE_W = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              k_inc,
    input  logic              tile_adv,
    input  logic [TILE_W-1:0] cfg_m,
    input  logic [TILE_W-1:0] cfg_k,
    input  logic [TILE_W-1:0] cfg_n,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W-1:0] act_addr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              acc_first,
    output logic              acc_last,
    output logic              tile_last
);

    logic [TILE_W-1:0] tm, tk, tn, m, n, k;
    logic [TILE_W-1:0] tm_nx, tk_nx, tn_nx, m_nx, n_nx, k_nx;

    function automatic logic [ADDR_W-1:0] tile_base(input logic [TILE_W-1:0] outer,
                                                    input logic [TILE_W-1:0] stride,
                                                    input logic [TILE_W-1:0] inner);
        logic [ADDR_W-1:0] idx;
        idx = ADDR_W'(outer) * ADDR_W'(stride) + ADDR_W'(inner);
        return idx * ADDR_W'(TILE_WORDS);
    endfunction

    assign tile_last = (m == tm - TILE_W'(1)) && (n == tn - TILE_W'(1));

    always_comb begin
        tm_nx = tm;
        tk_nx = tk;
        tn_nx = tn;
        m_nx  = m;
        n_nx  = n;
        k_nx  = k;
        if (clear) begin
            tm_nx = cfg_m;
            tk_nx = cfg_k;
            tn_nx = cfg_n;
            m_nx  = '0;
            n_nx  = '0;
            k_nx  = '0;
        end else if (k_inc) begin
            k_nx = k + TILE_W'(1);
        end else if (tile_adv) begin
            k_nx = '0;
            if (n == tn - TILE_W'(1)) begin
                n_nx = '0;
                m_nx = m + TILE_W'(1);
            end else begin
                n_nx = n + TILE_W'(1);
            end
        end
    end

    // Addresses and flags are built from the next indices so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tm        <= '0;
            tk        <= '0;
            tn        <= '0;
            m         <= '0;
            n         <= '0;
            k         <= '0;
            wt_addr   <= '0;
            act_addr  <= '0;
            out_addr  <= '0;
            acc_first <= 1'b0;
            acc_last  <= 1'b0;
        end else begin
            tm        <= tm_nx;
            tk        <= tk_nx;
            tn        <= tn_nx;
            m         <= m_nx;
            n         <= n_nx;
            k         <= k_nx;
            wt_addr   <= tile_base(k_nx, tn_nx, n_nx);
            act_addr  <= tile_base(m_nx, tk_nx, k_nx);
            out_addr  <= tile_base(m_nx, tn_nx, n_nx);
            acc_first <= (k_nx == '0);
            acc_last  <= (k_nx == tk_nx - TILE_W'(1));
        end
    end

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Sequences tiled GEMM (m outer, n, k inner) over the 8x8 core: load, run, wait, store per tile.
module tpu_tile_scheduler
    import tpu_pkg::*;
#(
    parameter int TILE_W  = 4,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    input  logic [TILE_W-1:0]          cfg_tiles_m,
    input  logic [TILE_W-1:0]          cfg_tiles_k,
    input  logic [TILE_W-1:0]          cfg_tiles_n,
    tpu_tile_scheduler_if.master       bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t            state;
    logic [TMO_W-1:0]  tmo;
    logic              done_prev;
    logic              load_req, core_start, store_req;
    logic              clear, k_inc, tile_adv;
    logic              acc_first, acc_last, tile_last;
    logic [ADDR_W-1:0] wt_addr, act_addr, out_addr;
    logic              zero_cfg, core_rise;

    assign zero_cfg  = (cfg_tiles_m == '0) || (cfg_tiles_k == '0) || (cfg_tiles_n == '0);
    assign core_rise = bus.core_done && !done_prev;

    always_comb begin
        clear    = 1'b0;
        k_inc    = 1'b0;
        tile_adv = 1'b0;
        if (!abort) begin
            case (state)
                S_IDLE:  clear    = start && !zero_cfg;
                S_WAIT:  k_inc    = core_rise && !acc_last;
                S_STORE: tile_adv = bus.store_ack;
                default: ;
            endcase
        end
    end

    tile_index_counter #(
        .TILE_W (TILE_W),
        .ADDR_W (ADDR_W)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .k_inc     (k_inc),
        .tile_adv  (tile_adv),
        .cfg_m     (cfg_tiles_m),
        .cfg_k     (cfg_tiles_k),
        .cfg_n     (cfg_tiles_n),
        .wt_addr   (wt_addr),
        .act_addr  (act_addr),
        .out_addr  (out_addr),
        .acc_first (acc_first),
        .acc_last  (acc_last),
        .tile_last (tile_last)
    );

    // done_prev tracks core_done every cycle, so a level already high on WAIT entry never counts as an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            tmo        <= '0;
            done_prev  <= 1'b0;
            load_req   <= 1'b0;
            core_start <= 1'b0;
            store_req  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done_prev  <= bus.core_done;
            done       <= 1'b0;
            core_start <= 1'b0;
            if (abort) begin
                state     <= S_IDLE;
                load_req  <= 1'b0;
                store_req <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        if (zero_cfg) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            load_req <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD: if (bus.load_ack) begin
                        load_req   <= 1'b0;
                        core_start <= 1'b1;
                        state      <= S_RUN;
                    end
                    S_RUN: begin
                        tmo   <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (core_rise) begin
                            if (acc_last) begin
                                store_req <= 1'b1;
                                state     <= S_STORE;
                            end else begin
                                load_req <= 1'b1;
                                state    <= S_LOAD;
                            end
                        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                    S_STORE: if (bus.store_ack) begin
                        store_req <= 1'b0;
                        if (tile_last) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            load_req <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                    S_FIN: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.load_req   = load_req;
    assign bus.core_start = core_start;
    assign bus.store_req  = store_req;
    assign bus.wt_addr    = wt_addr;
    assign bus.act_addr   = act_addr;
    assign bus.out_addr   = out_addr;
    assign bus.acc_first  = acc_first;
    assign bus.acc_last   = acc_last;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Scoreboard bench for tpu_tile_scheduler: DMA/core/UB responders plus per-scenario tasks.
module tb_tpu_tile_scheduler;

    localparam int LIMIT = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cfg_m = '0, cfg_k = '0, cfg_n = '0;
    logic       busy, done, err;
    logic       ld_ack = 1'b0, stray_ack = 1'b0, st_ack = 1'b0, core_done_r = 1'b0;

    int n_vec = 0, n_err = 0;
    int cyc = 0, n_cs = 0, n_done = 0, cs_cyc = 0, st_cyc = 0, done_cyc = 0, hold_viol = 0;
    bit busy_seen = 0, rand_ack = 0, job_to = 0;
    int core_mode = 0;

    logic [33:0] exp_ld[$], obs_ld[$];
    logic [15:0] exp_st[$], obs_st[$];

    tpu_tile_scheduler_if #(.ADDR_W(16)) bus ();

    assign bus.load_ack  = ld_ack | stray_ack;
    assign bus.store_ack = st_ack;
    assign bus.core_done = core_done_r;

    tpu_tile_scheduler #(.TILE_W(4), .ADDR_W(16), .TIMEOUT(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_tiles_m (cfg_m),
        .cfg_tiles_k (cfg_k),
        .cfg_tiles_n (cfg_n),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DMA load responder
    initial begin
        forever begin
            @(negedge clk);
            if (bus.load_req) begin
                int d;
                obs_ld.push_back({bus.wt_addr, bus.act_addr, bus.acc_first, bus.acc_last});
                d = rand_ack ? int'($urandom_range(20)) : 0;
                repeat (d) begin
                    @(negedge clk);
                    if (!bus.load_req) hold_viol++;
                end
                ld_ack = 1'b1;
                @(negedge clk);
                ld_ack = 1'b0;
                if (bus.load_req) hold_viol++;
            end
        end
    end

    // UB store responder
    initial begin
        forever begin
            @(negedge clk);
            if (bus.store_req) begin
                int d;
                obs_st.push_back(bus.out_addr);
                st_cyc = cyc;
                d = rand_ack ? int'($urandom_range(20)) : 0;
                repeat (d) begin
                    @(negedge clk);
                    if (!bus.store_req) hold_viol++;
                end
                st_ack = 1'b1;
                @(negedge clk);
                st_ack = 1'b0;
                if (bus.store_req) hold_viol++;
            end
        end
    end

    // Core model: mode 0 normal, 1 never finishes, 2 done already high at WAIT entry
    initial begin
        forever begin
            @(negedge clk);
            if (bus.core_start) begin
                n_cs++;
                cs_cyc = cyc;
                if (core_mode == 0) begin
                    repeat (2) @(negedge clk);
                    core_done_r = 1'b1;
                    @(negedge clk);
                    core_done_r = 1'b0;
                end else if (core_mode == 2) begin
                    core_done_r = 1'b1;
                    repeat (3) @(negedge clk);
                    core_done_r = 1'b0;
                    repeat (2) @(negedge clk);
                    core_done_r = 1'b1;
                    @(negedge clk);
                    core_done_r = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
        end
    end

    task automatic clear_obs();
        exp_ld.delete(); obs_ld.delete(); exp_st.delete(); obs_st.delete();
        n_cs = 0; n_done = 0; busy_seen = 0; hold_viol = 0; job_to = 0;
    endtask

    task automatic run_job(input int tm, input int tk, input int tn, input bit poke);
        int cnt;
        clear_obs();
        for (int m = 0; m < tm; m++)
            for (int n = 0; n < tn; n++) begin
                for (int k = 0; k < tk; k++)
                    exp_ld.push_back({16'((k * tn + n) * 64), 16'((m * tk + k) * 64), k == 0, k == tk - 1});
                exp_st.push_back(16'((m * tn + n) * 64));
            end
        cfg_m = 4'(tm); cfg_k = 4'(tk); cfg_n = 4'(tn);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (poke) begin
            repeat (8) @(negedge clk);
            cfg_m = 4'd1; cfg_k = 4'd1; cfg_n = 4'd1;
            start = 1'b1;
            @(negedge clk); start = 1'b0;
        end
        cnt = 0;
        while (n_done == 0 && cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
        end
        job_to = (n_done == 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({bus.load_req, bus.core_start, bus.store_req, busy, done, err, bus.acc_first, bus.acc_last} !== 8'h00) begin
            n_err++; $display("FAIL reset_ctrl got %b exp 00000000",
                {bus.load_req, bus.core_start, bus.store_req, busy, done, err, bus.acc_first, bus.acc_last});
        end
        n_vec++;
        if ({bus.wt_addr, bus.act_addr, bus.out_addr} !== 48'h0) begin
            n_err++; $display("FAIL reset_addr got %h exp 0", {bus.wt_addr, bus.act_addr, bus.out_addr});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [33:0] e, o;
        core_mode = 0; rand_ack = 0;
        run_job(1, 1, 1, 0);
        n_vec++; if (job_to !== 1'b0) begin n_err++; $display("FAIL single_timeout no done within %0d cycles", LIMIT); end
        n_vec++; if (n_cs !== 1) begin n_err++; $display("FAIL single_core_starts got %0d exp 1", n_cs); end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL single_done got %0d exp 1", n_done); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL single_err got %b exp 0", err); end
        n_vec++; if (st_cyc - cs_cyc !== 3) begin n_err++; $display("FAIL single_store_lat got %0d exp 3", st_cyc - cs_cyc); end
        n_vec++; if (obs_ld.size() !== exp_ld.size()) begin n_err++; $display("FAIL single_loads got %0d exp %0d", obs_ld.size(), exp_ld.size()); end
        while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
            e = exp_ld.pop_front(); o = obs_ld.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL single_load got %h exp %h", o, e); end
        end
        n_vec++; if (obs_st.size() !== 1 || obs_st[0] !== 16'd0) begin n_err++; $display("FAIL single_store got n=%0d exp one at 0", obs_st.size()); end
    endtask

    task automatic test_multi();
        logic [33:0] e, o;
        logic [15:0] es, os;
        core_mode = 0; rand_ack = 0;
        run_job(2, 3, 2, 1);
        n_vec++; if (job_to !== 1'b0) begin n_err++; $display("FAIL multi_timeout no done within %0d cycles", LIMIT); end
        n_vec++; if (n_cs !== 12) begin n_err++; $display("FAIL multi_core_starts got %0d exp 12", n_cs); end
        n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL multi_done got %0d exp 1", n_done); end
        n_vec++; if (obs_ld.size() !== exp_ld.size()) begin n_err++; $display("FAIL multi_loads got %0d exp %0d", obs_ld.size(), exp_ld.size()); end
        while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
            e = exp_ld.pop_front(); o = obs_ld.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL multi_load got %h exp %h", o, e); end
        end
        n_vec++; if (obs_st.size() !== exp_st.size()) begin n_err++; $display("FAIL multi_stores got %0d exp %0d", obs_st.size(), exp_st.size()); end
        while (exp_st.size() > 0 && obs_st.size() > 0) begin
            es = exp_st.pop_front(); os = obs_st.pop_front(); n_vec++;
            if (os !== es) begin n_err++; $display("FAIL multi_out_addr got %0d exp %0d", os, es); end
        end
    endtask

    task automatic test_zero_cfg();
        for (int z = 0; z < 3; z++) begin
            clear_obs();
            cfg_m = (z == 0) ? 4'd0 : 4'd2;
            cfg_k = (z == 1) ? 4'd0 : 4'd2;
            cfg_n = (z == 2) ? 4'd0 : 4'd2;
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            n_vec++; if ({done, err, busy} !== 3'b110) begin n_err++; $display("FAIL zero%0d_flags got done/err/busy=%b exp 110", z, {done, err, busy}); end
            @(negedge clk);
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero%0d_done_width got %b exp 0", z, done); end
            repeat (3) @(negedge clk);
            n_vec++; if (n_done !== 1 || busy_seen !== 1'b0 || obs_ld.size() !== 0) begin
                n_err++; $display("FAIL zero%0d_quiet got done=%0d busy_seen=%b loads=%0d exp 1 0 0", z, n_done, busy_seen, obs_ld.size());
            end
            run_job(1, 1, 1, 0);
            n_vec++; if (err !== 1'b0 || n_done !== 1) begin n_err++; $display("FAIL zero%0d_recover got err=%b done=%0d exp 0 1", z, err, n_done); end
        end
    endtask

    task automatic test_timeout();
        core_mode = 1; rand_ack = 0;
        run_job(1, 1, 1, 0);
        n_vec++; if (job_to !== 1'b0) begin n_err++; $display("FAIL timeout_nodone no done within %0d cycles", LIMIT); end
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL timeout_err got %b exp 1", err); end
        n_vec++; if (done_cyc - cs_cyc !== 256) begin n_err++; $display("FAIL timeout_len got %0d exp 256", done_cyc - cs_cyc); end
        n_vec++; if (obs_st.size() !== 0 || busy !== 1'b0 || n_done !== 1) begin
            n_err++; $display("FAIL timeout_end got stores=%0d busy=%b done=%0d exp 0 0 1", obs_st.size(), busy, n_done);
        end
        core_mode = 0;
    endtask

    task automatic test_done_high();
        core_mode = 2; rand_ack = 0;
        run_job(1, 1, 1, 0);
        n_vec++; if (st_cyc - cs_cyc !== 6) begin n_err++; $display("FAIL done_high_lat got %0d exp 6", st_cyc - cs_cyc); end
        n_vec++; if (n_done !== 1 || err !== 1'b0) begin n_err++; $display("FAIL done_high_end got done=%0d err=%b exp 1 0", n_done, err); end
        core_mode = 0;
    endtask

    task automatic test_abort();
        int seen, cnt;
        logic [33:0] e, o;
        core_mode = 0; rand_ack = 0;
        clear_obs();
        cfg_m = 4'd2; cfg_k = 4'd3; cfg_n = 4'd2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0; cnt = 0;
        while (seen < 2 && cnt < LIMIT) begin
            @(negedge clk); cnt++;
            if (bus.core_start) seen++;
        end
        n_vec++; if (seen !== 2) begin n_err++; $display("FAIL abort_setup core_starts got %0d exp 2", seen); end
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        n_vec++; if ({bus.load_req, bus.core_start, bus.store_req, busy, done, err} !== 6'b0) begin
            n_err++; $display("FAIL abort_idle got %b exp 000000", {bus.load_req, bus.core_start, bus.store_req, busy, done, err});
        end
        repeat (6) @(negedge clk);
        n_vec++; if (n_done !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL abort_nodone got done=%0d busy=%b exp 0 0", n_done, busy); end
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || bus.load_req !== 1'b0) begin n_err++; $display("FAIL abort_vs_start got busy=%b load_req=%b exp 0 0", busy, bus.load_req); end
        run_job(2, 3, 2, 0);
        n_vec++; if (n_cs !== 12 || n_done !== 1 || obs_st.size() !== 4) begin
            n_err++; $display("FAIL abort_restart got starts=%0d done=%0d stores=%0d exp 12 1 4", n_cs, n_done, obs_st.size());
        end
        while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
            e = exp_ld.pop_front(); o = obs_ld.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL abort_restart_load got %h exp %h", o, e); end
        end
    endtask

    task automatic test_random_acks();
        logic [33:0] e, o;
        logic [15:0] es, os;
        core_mode = 0; rand_ack = 1;
        @(negedge clk); stray_ack = 1'b1;
        @(negedge clk); stray_ack = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0 || bus.load_req !== 1'b0 || bus.core_start !== 1'b0) begin
            n_err++; $display("FAIL stray_ack got busy=%b load_req=%b core_start=%b exp 0 0 0", busy, bus.load_req, bus.core_start);
        end
        run_job(2, 3, 2, 0);
        n_vec++; if (job_to !== 1'b0 || n_cs !== 12) begin n_err++; $display("FAIL rand_job got timeout=%b starts=%0d exp 0 12", job_to, n_cs); end
        n_vec++; if (hold_viol !== 0) begin n_err++; $display("FAIL rand_hold got %0d violations exp 0", hold_viol); end
        n_vec++; if (obs_ld.size() !== exp_ld.size() || obs_st.size() !== exp_st.size()) begin
            n_err++; $display("FAIL rand_counts got %0d/%0d exp %0d/%0d", obs_ld.size(), obs_st.size(), exp_ld.size(), exp_st.size());
        end
        while (exp_ld.size() > 0 && obs_ld.size() > 0) begin
            e = exp_ld.pop_front(); o = obs_ld.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL rand_load got %h exp %h", o, e); end
        end
        while (exp_st.size() > 0 && obs_st.size() > 0) begin
            es = exp_st.pop_front(); os = obs_st.pop_front(); n_vec++;
            if (os !== es) begin n_err++; $display("FAIL rand_out_addr got %0d exp %0d", os, es); end
        end
        rand_ack = 0;
    endtask

    task automatic test_async_reset();
        cfg_m = 4'd2; cfg_k = 4'd3; cfg_n = 4'd2;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL areset_setup busy got %b exp 1", busy); end
        #2 rst = 1'b0;
        #1;
        n_vec++; if ({bus.load_req, bus.core_start, bus.store_req, busy, done, err} !== 6'b0) begin
            n_err++; $display("FAIL areset_ctrl got %b exp 000000", {bus.load_req, bus.core_start, bus.store_req, busy, done, err});
        end
        n_vec++; if ({bus.wt_addr, bus.act_addr, bus.out_addr, bus.acc_first, bus.acc_last} !== 50'h0) begin
            n_err++; $display("FAIL areset_addr got %h exp 0", {bus.wt_addr, bus.act_addr, bus.out_addr, bus.acc_first, bus.acc_last});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL areset_idle busy got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_zero_cfg();
        test_timeout();
        test_done_high();
        test_abort();
        test_random_acks();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
